// File: rtl/sram_gen2_pkg.sv
// sram_gen2_pkg: shared definitions for the sram_gen2 block.
//   - DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   - state_t                 : controller states (SWEEP clears the array, IDLE serves requests)
package sram_gen2_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_gen2_array.sv
// sram_gen2_array: DEPTH x DATA_W storage with one synchronous write port
// carrying byte-lane enables and one registered, read-first read port.
// Ports:
//   clk, rst_n      : clock, async active-low reset (read register only)
//   we, wadd, wdata : write enable, address, data
//   wbe             : per-byte write enables
//   re, radd        : read enable and address
//   rdata           : registered read data (holds when re=0)
module sram_gen2_array
  import sram_gen2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wadd,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     radd,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Byte-lane write port; the array itself has no reset and is cleared by the sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbe[i]) begin
          mem_r[wadd][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register; sampling mem_r on the same edge as the write gives read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[radd];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sram_gen2.sv
// sram_gen2: byte-enabled single-port SRAM wrapper with a clear sweep.
// After reset (or a clr request) the controller zeroes one word per cycle
// for DEPTH cycles while busy is high; requests arriving then are dropped
// and flagged on rej. In IDLE, wr/rd are forwarded to the storage array.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   wr, rd, add      : write/read requests sharing one word address
//   data_in, be      : write data and byte-lane enables
//   clr              : request to zero the whole array
//   data_out         : registered read data
//   rd_valid         : one-cycle pulse marking new data_out
//   busy             : high while the clear sweep runs
//   rej              : one-cycle pulse when a request was dropped during busy
module sram_gen2
  import sram_gen2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_W-1:0]     add,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  clr,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  rej
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_s;
  logic                rd_valid_r;
  logic                rej_r, rej_s;
  logic                we_s, re_s;
  logic [ADDR_W-1:0]   wadd_s;
  logic [DATA_W-1:0]   wdata_s;
  logic [LANES-1:0]    wbe_s;

  // Next-state logic and steering of the array write port between sweep and user traffic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    we_s    = 1'b0;
    re_s    = 1'b0;
    rej_s   = 1'b0;
    wadd_s  = add;
    wdata_s = data_in;
    wbe_s   = be;
    case (state_r)
      SWEEP: begin
        we_s    = 1'b1;
        wadd_s  = cnt_r;
        wdata_s = {DATA_W{1'b0}};
        wbe_s   = {LANES{1'b1}};
        rej_s   = wr | rd;
        // The counter wraps to 0 naturally after the last address.
        cnt_s   = cnt_r + ONE_ADDR;
        if (cnt_r == LAST_ADDR) begin
          state_s = IDLE;
        end else begin
          state_s = SWEEP;
        end
      end
      IDLE: begin
        we_s = wr;
        re_s = rd;
        if (clr) begin
          state_s = SWEEP;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = SWEEP;
        cnt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Controller state, sweep counter and output pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= SWEEP;
      cnt_r      <= {ADDR_W{1'b0}};
      rd_valid_r <= 1'b0;
      rej_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      rd_valid_r <= re_s;
      rej_r      <= rej_s;
    end
  end

  sram_gen2_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .wadd  (wadd_s),
    .wdata (wdata_s),
    .wbe   (wbe_s),
    .re    (re_s),
    .radd  (add),
    .rdata (data_out)
  );

  assign rd_valid = rd_valid_r;
  assign rej      = rej_r;
  assign busy     = (state_r == SWEEP);

endmodule

// File: tb/tb_sram_gen2.sv
// tb_sram_gen2: self-checking bench for sram_gen2.
// dut8 uses the default widths; dut32 (DATA_W=32) covers byte lanes and
// pending-read discard on reset. Expected read data is queued when a read
// is issued and compared by a monitor when rd_valid appears.
module tb_sram_gen2;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        wr8, rd8, clr8;
  logic [2:0]  add8;
  logic [7:0]  din8;
  logic [0:0]  be8;
  logic [7:0]  dout8;
  logic        rdv8, busy8, rej8;

  logic        wr32, rd32, clr32;
  logic [2:0]  add32;
  logic [31:0] din32;
  logic [3:0]  be32;
  logic [31:0] dout32;
  logic        rdv32, busy32, rej32;

  int tests = 0;
  int fails = 0;

  logic [7:0]  model8 [8];
  logic [7:0]  q8 [$];
  logic [31:0] q32 [$];

  always #5 clk = ~clk;

  sram_gen2 #(.DATA_W(8), .ADDR_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .wr(wr8), .rd(rd8), .add(add8),
    .data_in(din8), .be(be8), .clr(clr8), .data_out(dout8),
    .rd_valid(rdv8), .busy(busy8), .rej(rej8)
  );

  sram_gen2 #(.DATA_W(32), .ADDR_W(3)) dut32 (
    .clk(clk), .rst_n(rst_n), .wr(wr32), .rd(rd32), .add(add32),
    .data_in(din32), .be(be32), .clr(clr32), .data_out(dout32),
    .rd_valid(rdv32), .busy(busy32), .rej(rej32)
  );

  // Scoreboard monitors: pop and compare whenever a DUT flags new read data.
  always @(negedge clk) begin
    if (rdv8 === 1'b1) begin
      tests++;
      if (q8.size() == 0) begin
        fails++;
        $display("FAIL rd8_unexpected: rd_valid high with data %h, no read pending", dout8);
      end else begin
        logic [7:0] e8;
        e8 = q8.pop_front();
        if (dout8 !== e8) begin
          fails++;
          $display("FAIL rd8_data: got %h expected %h", dout8, e8);
        end
      end
    end
    if (rdv32 === 1'b1) begin
      tests++;
      if (q32.size() == 0) begin
        fails++;
        $display("FAIL rd32_unexpected: rd_valid high with data %h, no read pending", dout32);
      end else begin
        logic [31:0] e32;
        e32 = q32.pop_front();
        if (dout32 !== e32) begin
          fails++;
          $display("FAIL rd32_data: got %h expected %h", dout32, e32);
        end
      end
    end
  end

  task automatic cyc8(input logic w, input logic r, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr8 = w; rd8 = r; add8 = a; din8 = d; be8 = 1'b1;
    if (r) q8.push_back(model8[a]);
    if (w) model8[a] = d;
  endtask

  task automatic drain_check(input string name);
    cyc8(1'b0, 1'b0, 3'd0, 8'h00);
    cyc8(1'b0, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    tests++;
    if (q8.size() != 0 || q32.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_rd_valid: pending8=%0d pending32=%0d expected 0", name, q8.size(), q32.size());
    end
  endtask

  task automatic count_busy(input string name);
    int edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy8 == 1'b0) break;
    end
    tests++;
    if (edges != 8) begin
      fails++;
      $display("FAIL %s_busy_len: busy fell after %0d edges, expected 8", name, edges);
    end
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 8; a++) cyc8(1'b0, 1'b1, 3'(a), 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr8 = 1'b0; rd8 = 1'b0; clr8 = 1'b0; add8 = 3'd0; din8 = 8'h00; be8 = 1'b1;
    wr32 = 1'b0; rd32 = 1'b0; clr32 = 1'b0; add32 = 3'd0; din32 = 32'h0; be32 = 4'h0;
    for (int a = 0; a < 8; a++) model8[a] = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if (dout8 !== 8'h00) begin fails++; $display("FAIL reset_data_out: got %h expected 00", dout8); end
    tests++;
    if (rdv8 !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b expected 0", rdv8); end
    tests++;
    if (rej8 !== 1'b0) begin fails++; $display("FAIL reset_rej: got %b expected 0", rej8); end
    tests++;
    if (busy8 !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", busy8); end
  endtask

  task automatic test_initial_sweep();
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("init");
    read_all_zero();
    drain_check("init");
  endtask

  task automatic test_write_read();
    cyc8(1'b1, 1'b0, 3'd0, 8'hAA);
    cyc8(1'b1, 1'b0, 3'd1, 8'hBB);
    cyc8(1'b1, 1'b0, 3'd2, 8'hBB);
    cyc8(1'b0, 1'b1, 3'd0, 8'h00);
    cyc8(1'b0, 1'b1, 3'd1, 8'h00);
    cyc8(1'b0, 1'b1, 3'd2, 8'h00);
    drain_check("wr_rd");
  endtask

  task automatic test_byte_lanes();
    @(negedge clk); wr32 = 1'b1; add32 = 3'd5; din32 = 32'h11223344; be32 = 4'hF;
    @(negedge clk); din32 = 32'hAABBCCDD; be32 = 4'b0101;
    @(negedge clk); wr32 = 1'b0; rd32 = 1'b1; q32.push_back(32'h11BB33DD);
    @(negedge clk); rd32 = 1'b0; wr32 = 1'b1; din32 = 32'hFFFFFFFF; be32 = 4'h0;
    @(negedge clk); wr32 = 1'b0; rd32 = 1'b1; q32.push_back(32'h11BB33DD);
    @(negedge clk); rd32 = 1'b0;
    drain_check("lanes");
  endtask

  task automatic test_read_first();
    cyc8(1'b1, 1'b0, 3'd3, 8'h5A);
    cyc8(1'b1, 1'b1, 3'd3, 8'hC3);
    cyc8(1'b0, 1'b1, 3'd3, 8'h00);
    drain_check("rd_first");
  endtask

  task automatic test_clear_sweep();
    int busy_n = 0;
    int rej_n = 0;
    for (int a = 0; a < 8; a++) cyc8(1'b1, 1'b0, 3'(a), 8'(8'h11 * (a + 1)));
    @(negedge clk); wr8 = 1'b0; clr8 = 1'b1;
    for (int a = 0; a < 8; a++) model8[a] = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy8 === 1'b1) busy_n++;
      if (rej8 === 1'b1) rej_n++;
      clr8 = (i == 3) ? 1'b1 : 1'b0;
      if (i == 0) begin wr8 = 1'b1; add8 = 3'd0; din8 = 8'hFF; end
      else wr8 = 1'b0;
    end
    tests++;
    if (busy_n != 8) begin fails++; $display("FAIL clr_busy_len: busy high %0d cycles, expected 8", busy_n); end
    tests++;
    if (rej_n != 1) begin fails++; $display("FAIL clr_rej_count: rej pulsed %0d times, expected 1", rej_n); end
    read_all_zero();
    drain_check("clr");
  endtask

  task automatic test_reset_mid_sweep();
    int rdv_n = 0;
    for (int a = 0; a < 8; a++) cyc8(1'b1, 1'b0, 3'(a), 8'hE7);
    @(negedge clk); wr8 = 1'b0; clr8 = 1'b1;
    @(negedge clk); clr8 = 1'b0;
    repeat (3) @(negedge clk);
    rd32 = 1'b1; add32 = 3'd5;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (rdv32 !== 1'b0) begin fails++; $display("FAIL rst_pending_rd_valid: got %b expected 0", rdv32); end
    tests++;
    if (dout32 !== 32'h0) begin fails++; $display("FAIL rst_data_out: got %h expected 0", dout32); end
    rd32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rdv8 !== 1'b0 || rdv32 !== 1'b0) rdv_n++;
    end
    tests++;
    if (rdv_n != 0) begin fails++; $display("FAIL rst_rd_valid_rise: rd_valid high %0d times in reset, expected 0", rdv_n); end
    tests++;
    if (busy8 !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b expected 1", busy8); end
    for (int a = 0; a < 8; a++) model8[a] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("rst_mid");
    read_all_zero();
    drain_check("rst_mid");
  endtask

  initial begin
    test_reset();
    test_initial_sweep();
    test_write_read();
    test_byte_lanes();
    test_read_first();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_gen2.md
SRAM_GEN2 -- requirements
Module: sram_gen2

Interface
REQ-001 Parameter DATA_W, default 8, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W words.
REQ-003 Derived constant LANES = DATA_W/8, the number of byte lanes.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-006 Port wr, input, 1, write request for the current cycle.
REQ-007 Port rd, input, 1, read request for the current cycle.
REQ-008 Port add, input, ADDR_W, word address shared by wr and rd.
REQ-009 Port data_in, input, DATA_W, write data.
REQ-010 Port be, input, LANES, byte-lane write enables; bit i gates data_in[8i+7:8i].
REQ-011 Port clr, input, 1, single-cycle request to zero the whole array.
REQ-012 Port data_out, output, DATA_W, registered read data.
REQ-013 Port rd_valid, output, 1, one-cycle pulse marking new data_out.
REQ-014 Port busy, output, 1, high while a clear sweep is running.
REQ-015 Port rej, output, 1, one-cycle pulse when a wr or rd is dropped because busy is high.

Function
REQ-016 The FSM SHALL have two states: SWEEP and IDLE.
REQ-017 In SWEEP, one word per cycle SHALL be written to zero, at addresses 0..DEPTH-1 in order, using an internal ADDR_W-bit counter.
REQ-018 After the write at address DEPTH-1, the FSM SHALL go to IDLE, the counter SHALL wrap to 0, and busy SHALL fall on that same edge.
REQ-019 A sweep SHALL take exactly DEPTH cycles.
REQ-020 In IDLE, clr=1 SHALL enter SWEEP on the next edge.
- Any wr or rd in that same cycle is still serviced.
REQ-021 In SWEEP, clr SHALL be ignored.
- The sweep is not restarted and no rej pulse is raised.
REQ-022 In IDLE, wr=1 SHALL update only the lanes where be=1 at word add; other lanes keep their value.
- wr=1 with be=0 leaves memory unchanged.
REQ-023 In IDLE, rd=1 at edge N SHALL load data_out with mem[add] and raise rd_valid for the cycle after edge N (latency 1).
REQ-024 When rd=0, data_out SHALL hold its last value and rd_valid SHALL be 0.
REQ-025 If wr=1 and rd=1 in the same cycle at the same add, the read SHALL return the old word (read-first), and the write SHALL complete.
REQ-026 In SWEEP, wr and rd SHALL be dropped: no memory change, data_out held, rd_valid=0.
- If wr|rd=1, rej SHALL pulse high for the cycle after that edge.
REQ-027 No output SHALL be combinationally derived from wr, rd, add or data_in.

Reset
REQ-028 While rst_n=0, the outputs SHALL be: data_out=0, rd_valid=0, rej=0, busy=1.
REQ-029 While rst_n=0, the state SHALL be SWEEP and the counter SHALL be 0.
REQ-030 The first sweep write SHALL occur at the first rising edge after rst_n rises.
REQ-031 Reset asserted mid-sweep or mid-read SHALL restart the sweep from address 0 and discard any pending rd_valid.
REQ-032 Array contents SHALL NOT be reset directly; they are cleared only by the sweep.

Structure
REQ-033 Package sram_gen2_pkg SHALL hold the state enumeration (SWEEP, IDLE) and the default values of DATA_W and ADDR_W.
REQ-034 Storage SHALL be the sub-module sram_gen2_array: a DEPTH x DATA_W array with one synchronous write port with byte-lane enables and one registered, read-first read port.
REQ-035 The FSM, sweep counter, request gating and rej/rd_valid logic SHALL live in sram_gen2.

Verification (defaults DATA_W=8, ADDR_W=3; bench uses DATA_W=32 for the byte-lane test)
REQ-036 Release rst_n, then hold wr=rd=0: busy=1 for exactly 8 cycles, then 0; rd at every address 0..7 returns 8'h00 with rd_valid.
REQ-037 Write 8'hAA@0, 8'hBB@1, 8'hBB@2, then read 0, 1, 2: data_out = AA, BB, BB, each one cycle after its rd, with rd_valid pulsed.
REQ-038 DATA_W=32: write 32'h11223344@5 with be=4'hF, then 32'hAABBCCDD@5 with be=4'b0101; reading address 5 returns 32'h11BB33DD.
REQ-039 With mem[3]=8'h5A, assert wr=1, rd=1, add=3, data_in=8'hC3 in one cycle: data_out=8'h5A; the next read of address 3 returns 8'hC3.
REQ-040 After filling memory, pulse clr, then issue wr@0 during the sweep: rej pulses once and busy is high for 8 cycles; afterwards all addresses read 8'h00.
REQ-041 Drop rst_n at sweep count 4, then release: busy stays high for a full 8 cycles from the release, and rd_valid never rises during reset.
